// File: rtl/sa_autosa_sdp_wdma_pkg.sv
// ---------------------------------------------------------------------------
// sa_autosa_sdp_wdma_pkg
// Shared definitions for the SDP write-DMA command generator and data stage.
// Both sides take payload field positions from here, so the command layout
// is defined in exactly one place.
//   AW / SW            : address width (8-byte atoms) and size-field width
//   SPT_* / DMA_*      : bit offsets of cube_end, odd, size and addr fields
//   wdma_cmd_state_e   : command generator state encoding
//   odd_atoms()        : odd-atom-count flag derived from a width-minus-1 field
// ---------------------------------------------------------------------------
package sa_autosa_sdp_wdma_pkg;

    localparam int AW = 29;
    localparam int SW = 13;

    // split command payload: {cube_end, odd, size}
    localparam int SPT_SIZE_LSB     = 0;
    localparam int SPT_ODD_BIT      = SW;
    localparam int SPT_CUBE_END_BIT = SW + 1;
    localparam int SPT_PD_W         = SW + 2;

    // DMA command payload: {cube_end, odd, size, addr}
    localparam int DMA_ADDR_LSB     = 0;
    localparam int DMA_SIZE_LSB     = AW;
    localparam int DMA_ODD_BIT      = AW + SW;
    localparam int DMA_CUBE_END_BIT = AW + SW + 1;
    localparam int DMA_PD_W         = AW + SW + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } wdma_cmd_state_e;

    // The width field holds atoms-minus-1, so an even field value means an
    // odd number of atoms in the line.
    function automatic logic odd_atoms(input logic [SW-1:0] width_m1);
        return ~width_m1[0];
    endfunction

endpackage

// File: rtl/sa_autosa_sdp_wdma_cmd_fork.sv
// ---------------------------------------------------------------------------
// sa_autosa_sdp_wdma_cmd_fork
// Two-way valid/ready fork. One upstream "pair valid" is offered to two
// downstream branches; each branch keeps a sent flag so an accepted branch is
// not offered again while the other branch is still waiting.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_vld             : a command pair is being presented
//   i_a_rdy, i_b_rdy  : branch ready inputs
//   o_a_vld, o_b_vld  : branch valid outputs (gated by the sent flags)
//   o_done            : both branches accepted; pair completes this edge
// ---------------------------------------------------------------------------
module sa_autosa_sdp_wdma_cmd_fork (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vld,
    input  logic i_a_rdy,
    input  logic i_b_rdy,
    output logic o_a_vld,
    output logic o_b_vld,
    output logic o_done
);

    logic r_a_sent;
    logic r_b_sent;
    logic w_a_acc;
    logic w_b_acc;

    assign o_a_vld = i_vld & ~r_a_sent;
    assign o_b_vld = i_vld & ~r_b_sent;
    assign w_a_acc = o_a_vld & i_a_rdy;
    assign w_b_acc = o_b_vld & i_b_rdy;

    // A branch counts as delivered if it was sent earlier or is accepted now.
    assign o_done  = i_vld & (r_a_sent | w_a_acc) & (r_b_sent | w_b_acc);

    // Per-branch sent flags: set on accept, cleared when the pair completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sent <= 1'b0;
            r_b_sent <= 1'b0;
        end else if (o_done) begin
            r_a_sent <= 1'b0;
            r_b_sent <= 1'b0;
        end else begin
            r_a_sent <= r_a_sent | w_a_acc;
            r_b_sent <= r_b_sent | w_b_acc;
        end
    end

endmodule

// File: rtl/sa_autosa_sdp_wdma_cmd_gen.sv
// ---------------------------------------------------------------------------
// sa_autosa_sdp_wdma_cmd_gen
// Walks an output cube surface by surface, line by line, and emits one
// split command and one DMA command per line. All payload bits come straight
// from registers; ready only affects valid through the fork's sent flags.
//   autosa_core_clk / autosa_core_rst : clock, synchronous active-high reset
//   op_load                           : start pulse, latches reg2dp_* in IDLE
//   reg2dp_width/height/channel       : atoms/line-1, lines/surface-1, surfaces-1
//   reg2dp_dst_base_addr              : first atom address
//   reg2dp_dst_line/surface_stride    : atom strides between lines / surfaces
//   cmd2dat_spt_{pvld,prdy,pd}        : split command {cube_end, odd, size}
//   cmd2dat_dma_{pvld,prdy,pd}        : DMA command {cube_end, odd, size, addr}
//   busy                              : cube in progress (ISSUE and DONE)
// The AW/SW parameters must match the package values, since the payload is
// packed with the package field offsets shared with the data stage.
// ---------------------------------------------------------------------------
module sa_autosa_sdp_wdma_cmd_gen #(
    parameter int AW = sa_autosa_sdp_wdma_pkg::AW,
    parameter int SW = sa_autosa_sdp_wdma_pkg::SW
) (
    input  logic             autosa_core_clk,
    input  logic             autosa_core_rst,
    input  logic             op_load,
    input  logic [SW-1:0]    reg2dp_width,
    input  logic [SW-1:0]    reg2dp_height,
    input  logic [SW-1:0]    reg2dp_channel,
    input  logic [AW-1:0]    reg2dp_dst_base_addr,
    input  logic [AW-1:0]    reg2dp_dst_line_stride,
    input  logic [AW-1:0]    reg2dp_dst_surface_stride,
    output logic             cmd2dat_spt_pvld,
    input  logic             cmd2dat_spt_prdy,
    output logic [SW+1:0]    cmd2dat_spt_pd,
    output logic             cmd2dat_dma_pvld,
    input  logic             cmd2dat_dma_prdy,
    output logic [AW+SW+1:0] cmd2dat_dma_pd,
    output logic             busy
);

    import sa_autosa_sdp_wdma_pkg::*;

    wdma_cmd_state_e r_state;
    logic            r_busy;
    logic [SW-1:0]   r_width;
    logic [SW-1:0]   r_height;
    logic [SW-1:0]   r_channel;
    logic [AW-1:0]   r_line_stride;
    logic [AW-1:0]   r_surf_stride;
    logic [AW-1:0]   r_line_addr;
    logic [AW-1:0]   r_surf_addr;
    logic [SW-1:0]   r_line_cnt;
    logic [SW-1:0]   r_surf_cnt;
    logic            r_odd;
    logic            r_cube_end;

    logic            w_issue;
    logic            w_pair_done;
    logic [SW-1:0]   w_next_line_cnt;
    logic [SW-1:0]   w_next_surf_cnt;
    logic [AW-1:0]   w_next_line_addr;
    logic [AW-1:0]   w_next_surf_addr;
    logic            w_next_cube_end;
    logic [SPT_PD_W-1:0] w_spt_pd;
    logic [DMA_PD_W-1:0] w_dma_pd;

    assign w_issue = (r_state == ST_ISSUE);

    sa_autosa_sdp_wdma_cmd_fork u_fork (
        .i_clk   (autosa_core_clk),
        .i_rst   (autosa_core_rst),
        .i_vld   (w_issue),
        .i_a_rdy (cmd2dat_spt_prdy),
        .i_b_rdy (cmd2dat_dma_prdy),
        .o_a_vld (cmd2dat_spt_pvld),
        .o_b_vld (cmd2dat_dma_pvld),
        .o_done  (w_pair_done)
    );

    // Next line/surface position after the current pair completes. The
    // cube_end flag is precomputed here so the payload stays register-driven.
    always_comb begin
        w_next_line_cnt  = r_line_cnt;
        w_next_surf_cnt  = r_surf_cnt;
        w_next_line_addr = r_line_addr;
        w_next_surf_addr = r_surf_addr;
        if (r_line_cnt != r_height) begin
            w_next_line_cnt  = r_line_cnt + {{(SW-1){1'b0}}, 1'b1};
            w_next_line_addr = r_line_addr + r_line_stride;
        end else begin
            w_next_line_cnt  = {SW{1'b0}};
            w_next_surf_cnt  = r_surf_cnt + {{(SW-1){1'b0}}, 1'b1};
            w_next_surf_addr = r_surf_addr + r_surf_stride;
            w_next_line_addr = r_surf_addr + r_surf_stride;
        end
        w_next_cube_end = (w_next_line_cnt == r_height) && (w_next_surf_cnt == r_channel);
    end

    // Control FSM with config latch, counters and address walkers.
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_width       <= {SW{1'b0}};
            r_height      <= {SW{1'b0}};
            r_channel     <= {SW{1'b0}};
            r_line_stride <= {AW{1'b0}};
            r_surf_stride <= {AW{1'b0}};
            r_line_addr   <= {AW{1'b0}};
            r_surf_addr   <= {AW{1'b0}};
            r_line_cnt    <= {SW{1'b0}};
            r_surf_cnt    <= {SW{1'b0}};
            r_odd         <= 1'b0;
            r_cube_end    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_load) begin
                        r_width       <= reg2dp_width;
                        r_height      <= reg2dp_height;
                        r_channel     <= reg2dp_channel;
                        r_line_stride <= reg2dp_dst_line_stride;
                        r_surf_stride <= reg2dp_dst_surface_stride;
                        r_line_addr   <= reg2dp_dst_base_addr;
                        r_surf_addr   <= reg2dp_dst_base_addr;
                        r_line_cnt    <= {SW{1'b0}};
                        r_surf_cnt    <= {SW{1'b0}};
                        r_odd         <= odd_atoms(reg2dp_width);
                        r_cube_end    <= (reg2dp_height == {SW{1'b0}}) &&
                                         (reg2dp_channel == {SW{1'b0}});
                        r_busy        <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end else begin
                        r_state       <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // op_load is deliberately not looked at here.
                    if (w_pair_done && r_cube_end) begin
                        r_state <= ST_DONE;
                    end else if (w_pair_done) begin
                        r_line_cnt  <= w_next_line_cnt;
                        r_surf_cnt  <= w_next_surf_cnt;
                        r_line_addr <= w_next_line_addr;
                        r_surf_addr <= w_next_surf_addr;
                        r_cube_end  <= w_next_cube_end;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload packing at the shared field offsets.
    always_comb begin
        w_spt_pd = {SPT_PD_W{1'b0}};
        w_spt_pd[SPT_CUBE_END_BIT]  = r_cube_end;
        w_spt_pd[SPT_ODD_BIT]       = r_odd;
        w_spt_pd[SPT_SIZE_LSB +: SW] = r_width;
        w_dma_pd = {DMA_PD_W{1'b0}};
        w_dma_pd[DMA_CUBE_END_BIT]  = r_cube_end;
        w_dma_pd[DMA_ODD_BIT]       = r_odd;
        w_dma_pd[DMA_SIZE_LSB +: SW] = r_width;
        w_dma_pd[DMA_ADDR_LSB +: AW] = r_line_addr;
    end

    assign cmd2dat_spt_pd = w_spt_pd;
    assign cmd2dat_dma_pd = w_dma_pd;
    assign busy           = r_busy;

endmodule

// File: tb/tb_sa_autosa_sdp_wdma_cmd_gen.sv
module tb_sa_autosa_sdp_wdma_cmd_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_load = 1'b0;
    logic [12:0] reg_width = 13'd0;
    logic [12:0] reg_height = 13'd0;
    logic [12:0] reg_channel = 13'd0;
    logic [28:0] reg_base = 29'd0;
    logic [28:0] reg_ls = 29'd0;
    logic [28:0] reg_ss = 29'd0;
    logic        spt_pvld;
    logic        spt_prdy = 1'b0;
    logic [14:0] spt_pd;
    logic        dma_pvld;
    logic        dma_prdy = 1'b0;
    logic [43:0] dma_pd;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    // configuration the reference model works from
    logic [12:0] cfg_w, cfg_h, cfg_c;
    logic [28:0] cfg_base, cfg_ls, cfg_ss;

    always #5 clk = ~clk;

    sa_autosa_sdp_wdma_cmd_gen dut (
        .autosa_core_clk           (clk),
        .autosa_core_rst           (rst),
        .op_load                   (op_load),
        .reg2dp_width              (reg_width),
        .reg2dp_height             (reg_height),
        .reg2dp_channel            (reg_channel),
        .reg2dp_dst_base_addr      (reg_base),
        .reg2dp_dst_line_stride    (reg_ls),
        .reg2dp_dst_surface_stride (reg_ss),
        .cmd2dat_spt_pvld          (spt_pvld),
        .cmd2dat_spt_prdy          (spt_prdy),
        .cmd2dat_spt_pd            (spt_pd),
        .cmd2dat_dma_pvld          (dma_pvld),
        .cmd2dat_dma_prdy          (dma_prdy),
        .cmd2dat_dma_pd            (dma_pd),
        .busy                      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_pairs();
        return (int'(cfg_h) + 1) * (int'(cfg_c) + 1);
    endfunction

    // Line k of the cube: surface k/(H+1), line k%(H+1), address mod 2^29.
    function automatic logic [28:0] exp_addr(input int k);
        longint unsigned a;
        int lines;
        lines = int'(cfg_h) + 1;
        a = longint'(cfg_base) + longint'(k / lines) * longint'(cfg_ss)
            + longint'(k % lines) * longint'(cfg_ls);
        a = a % (64'd1 << 29);
        return 29'(a);
    endfunction

    function automatic logic [14:0] exp_spt(input int k);
        logic odd;
        logic last;
        odd  = (((int'(cfg_w) + 1) % 2) == 1);
        last = (k == n_pairs() - 1);
        return {last, odd, cfg_w};
    endfunction

    function automatic logic [43:0] exp_dma(input int k);
        logic [14:0] s;
        s = exp_spt(k);
        return {s, exp_addr(k)};
    endfunction

    task automatic set_cfg(input logic [12:0] w, input logic [12:0] h, input logic [12:0] c,
                           input logic [28:0] b, input logic [28:0] ls, input logic [28:0] ss);
        cfg_w = w; cfg_h = h; cfg_c = c; cfg_base = b; cfg_ls = ls; cfg_ss = ss;
    endtask

    task automatic start_cube();
        @(negedge clk);
        reg_width = cfg_w; reg_height = cfg_h; reg_channel = cfg_c;
        reg_base = cfg_base; reg_ls = cfg_ls; reg_ss = cfg_ss;
        op_load = 1'b1;
        @(posedge clk);
        #1 op_load = 1'b0;
    endtask

    // mode 0: both ready; 1: random readies; 2: dma ready low for 5 cycles.
    // inject_at >= 0 pulses op_load with a different width at that cycle.
    // stop_pairs > 0 stops the walk once that many pairs are due to complete.
    task automatic run_cube(input int mode, input int inject_at, input int stop_pairs);
        int n, stop, si, di, p, cyc;
        logic e_sv, e_dv;
        n = n_pairs();
        stop = (stop_pairs > 0) ? stop_pairs : n;
        si = 0; di = 0; cyc = 0;
        while (((si < di) ? si : di) < stop && cyc < n * 24 + 24) begin
            @(negedge clk);
            case (mode)
                0: begin spt_prdy = 1'b1; dma_prdy = 1'b1; end
                1: begin spt_prdy = 1'($urandom_range(0, 1)); dma_prdy = 1'($urandom_range(0, 1)); end
                default: begin spt_prdy = 1'b1; dma_prdy = (cyc >= 5); end
            endcase
            if (cyc == inject_at) begin
                op_load = 1'b1;
                reg_width = cfg_w ^ 13'h0005;
            end else begin
                op_load = 1'b0;
            end
            #1;
            p = (si < di) ? si : di;
            e_sv = (si == p);
            e_dv = (di == p);
            check("spt_pvld", spt_pvld, e_sv);
            check("dma_pvld", dma_pvld, e_dv);
            check("busy_issue", busy, 1'b1);
            if (e_sv) check("spt_pd", spt_pd, exp_spt(si));
            if (e_dv) check("dma_pd", dma_pd, exp_dma(di));
            if (e_sv && spt_prdy) si++;
            if (e_dv && dma_prdy) di++;
            cyc++;
        end
        op_load = 1'b0;
        reg_width = cfg_w;
        check("walk_timeout", (((si < di) ? si : di) < stop), 1'b0);
        if (stop_pairs == 0) begin
            if (mode == 0) check("throughput_cycles", cyc, n);
            @(negedge clk); #1;
            check("done_spt_pvld", spt_pvld, 1'b0);
            check("done_dma_pvld", dma_pvld, 1'b0);
            check("done_busy", busy, 1'b1);
            @(negedge clk); #1;
            check("idle_busy", busy, 1'b0);
            check("idle_spt_pvld", spt_pvld, 1'b0);
        end
    endtask

    initial begin
        set_cfg(13'd0, 13'd0, 13'd0, 29'd0, 29'd0, 29'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_spt_pvld", spt_pvld, 1'b0);
        check("rst_dma_pvld", dma_pvld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_spt_pd", spt_pd, 15'd0);
        check("rst_dma_pd", dma_pd, 44'd0);

        // single line cube
        set_cfg(13'd3, 13'd0, 13'd0, 29'h100, 29'h10, 29'h40);
        start_cube();
        run_cube(0, -1, 0);

        // two surfaces of two lines
        set_cfg(13'd6, 13'd1, 13'd1, 29'h1000, 29'h10, 29'h40);
        start_cube();
        run_cube(0, -1, 0);
        start_cube();
        run_cube(1, -1, 0);

        // dma side held off while the split side is ready
        set_cfg(13'd9, 13'd1, 13'd0, 29'h2000, 29'h20, 29'h80);
        start_cube();
        run_cube(2, -1, 0);

        // address wrap
        set_cfg(13'd2, 13'd1, 13'd0, 29'h1FFFFFF8, 29'h10, 29'h100);
        start_cube();
        run_cube(0, -1, 0);

        // load pulse while busy is ignored
        set_cfg(13'd4, 13'd2, 13'd1, 29'h3000, 29'h8, 29'h100);
        start_cube();
        run_cube(0, 2, 0);

        // reset after two of four pairs, then restart from base
        set_cfg(13'd5, 13'd1, 13'd1, 29'h4000, 29'h10, 29'h40);
        start_cube();
        run_cube(0, -1, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_spt_pvld", spt_pvld, 1'b0);
        check("midrst_dma_pvld", dma_pvld, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        start_cube();
        run_cube(0, -1, 0);

        // random cubes with random readies
        for (int r = 0; r < 6; r++) begin
            set_cfg(13'($urandom), 13'($urandom_range(0, 3)), 13'($urandom_range(0, 3)),
                    29'($urandom), 29'($urandom), 29'($urandom));
            start_cube();
            run_cube(1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
